dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the MEM-stage CPU port has priority over a debug/loader port.
// Optional starvation guard for the debug port is enabled by defining DMEM_ARB_FAIR_EN.
module dmem_arbiter #(
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mr,
  output logic [31:0] mqb,
  output logic        mwmem,
  input  logic [31:0] mdo,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DBG  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } acc_t;

  state_t state;
  state_t state_nxt;

  logic   cpu_grant;
  logic   dbg_grant;
  logic   dbg_ok;
  logic   fair_ovr;
  logic   c_inr;
  logic   d_inr;
  logic   sel_inr;
  acc_t   sel;

  assign c_inr = (c_addr < 32'(DEPTH));
  assign d_inr = (d_addr < 32'(DEPTH));

  // A debug request acked this cycle was granted last cycle; it must not be re-granted.
  assign dbg_ok = d_req && (state != ST_DBG);

`ifdef DMEM_ARB_FAIR_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] streak;

  // Consecutive CPU wins while debug waits; saturates at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      streak <= '0;
    end else if (dbg_grant || !d_req) begin
      streak <= '0;
    end else if (cpu_grant && (streak != SW'(STARVE_LIMIT))) begin
      streak <= streak + SW'(1);
    end
  end

  assign fair_ovr = dbg_ok && (streak == SW'(STARVE_LIMIT));
`else
  assign fair_ovr = 1'b0;
`endif

  // Next owner and all combinational memory-side / CPU-side outputs.
  always_comb begin
    state_nxt = ST_IDLE;
    cpu_grant = 1'b0;
    dbg_grant = 1'b0;
    sel       = '0;
    sel_inr   = 1'b1;
    mr        = '0;
    mqb       = '0;
    mwmem     = 1'b0;
    err       = 1'b0;
    c_rdata   = '0;
    c_stall   = 1'b0;

    cpu_grant = c_req && !fair_ovr;
    dbg_grant = dbg_ok && !cpu_grant;

    if (cpu_grant) begin
      state_nxt = ST_CPU;
      sel       = '{addr: c_addr, wdata: c_wdata, we: c_we};
      sel_inr   = c_inr;
    end else if (dbg_grant) begin
      state_nxt = ST_DBG;
      sel       = '{addr: d_addr, wdata: d_wdata, we: d_we};
      sel_inr   = d_inr;
    end

    mr    = sel.addr;
    mqb   = sel.wdata;
    mwmem = sel.we && sel_inr;
    err   = (cpu_grant || dbg_grant) && !sel_inr;

    if (cpu_grant && !c_we && c_inr) begin
      c_rdata = mdo;
    end
    c_stall = c_req && !cpu_grant;
  end

  // Owner-of-previous-cycle state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Debug completion: read data captured at the end of the grant cycle, ack one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_ack   <= 1'b0;
      d_rdata <= '0;
    end else begin
      d_ack <= dbg_grant;
      if (dbg_grant) begin
        d_rdata <= (!d_we && d_inr) ? mdo : 32'd0;
      end
    end
  end

endmodule
